// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch / load-store memory arbiter.
// Imported by mem_arbiter and mem_arb_starve_ctr.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnIf = 1'b0,
        OwnLs = 1'b1
    } owner_e;

    // Access-size masks carried on LsWmask / MemWmask.
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0010;
    localparam logic [3:0] MASK_W = 4'b0100;
    localparam logic [3:0] MASK_D = 4'b1000;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts arbitrations lost by fetch while it was requesting; asserts force_if_o
// once the count reaches STARVE_MAX. Only built with MEM_ARB_STARVE_GUARD_EN.
module mem_arb_starve_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_i,
    input  logic if_valid_i,
    input  logic if_win_i,
    output logic force_if_o
);

    localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (arb_i) begin
            if (if_win_i) begin
                cnt_d = '0;
            end else if (if_valid_i && (cnt_q != CntMax)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if_o = (cnt_q == CntMax);

endmodule

// File: rtl/mem_arbiter.sv
// Two-client (fetch, load-store) arbiter onto a single memory port, one transaction
// outstanding. Define MEM_ARB_STARVE_GUARD_EN to enable the fetch starvation guard.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // Fetch port
    input  logic              if_req_valid_i,
    output logic              if_req_ready_o,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_resp_valid_o,
    output logic [DATA_W-1:0] if_resp_data_o,
    // Load-store port
    input  logic              ls_req_valid_i,
    output logic              ls_req_ready_o,
    input  logic              ls_write_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    input  logic [3:0]        ls_wmask_i,
    output logic              ls_resp_valid_o,
    output logic [DATA_W-1:0] ls_resp_data_o,
    // Shared memory port
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_wmask_o,
    input  logic              mem_resp_valid_i,
    input  logic [DATA_W-1:0] mem_resp_data_i
);

    if (STARVE_MAX == 0) begin : g_bad_starve_max
        $error("STARVE_MAX must be at least 1");
    end

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic              if_resp_valid_q, if_resp_valid_d;
    logic [DATA_W-1:0] if_resp_data_q, if_resp_data_d;
    logic              ls_resp_valid_q, ls_resp_valid_d;
    logic [DATA_W-1:0] ls_resp_data_q, ls_resp_data_d;

    logic grant_if, grant_ls, accept;
    logic force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .arb_i      (accept),
        .if_valid_i (if_req_valid_i),
        .if_win_i   (grant_if),
        .force_if_o (force_if)
    );
`else
    assign force_if = 1'b0;
`endif

    // Grants are only offered in IDLE; load-store wins unless the guard forces fetch.
    always_comb begin
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if (state_q == StIdle) begin
            grant_ls = ls_req_valid_i && !(force_if && if_req_valid_i);
            grant_if = if_req_valid_i && !grant_ls;
        end
    end

    assign accept = grant_ls || grant_if;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        mem_write_d     = mem_write_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wmask_d     = mem_wmask_q;
        if_resp_valid_d = 1'b0;
        if_resp_data_d  = if_resp_data_q;
        ls_resp_valid_d = 1'b0;
        ls_resp_data_d  = ls_resp_data_q;

        unique case (state_q)
            StIdle: begin
                if (grant_ls) begin
                    state_d     = StIssue;
                    owner_d     = OwnLs;
                    mem_write_d = ls_write_i;
                    mem_addr_d  = ls_addr_i;
                    mem_wdata_d = ls_wdata_i;
                    mem_wmask_d = ls_wmask_i;
                end else if (grant_if) begin
                    state_d     = StIssue;
                    owner_d     = OwnIf;
                    mem_write_d = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                    mem_wmask_d = MASK_D;
                end
            end
            StIssue: begin
                if (mem_req_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_resp_valid_i) begin
                    state_d = StIdle;
                    if (owner_q == OwnLs) begin
                        ls_resp_valid_d = 1'b1;
                        ls_resp_data_d  = mem_write_q ? '0 : mem_resp_data_i;
                    end else begin
                        if_resp_valid_d = 1'b1;
                        if_resp_data_d  = mem_resp_data_i;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            owner_q         <= OwnIf;
            mem_write_q     <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            if_resp_valid_q <= 1'b0;
            if_resp_data_q  <= '0;
            ls_resp_valid_q <= 1'b0;
            ls_resp_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            mem_write_q     <= mem_write_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wmask_q     <= mem_wmask_d;
            if_resp_valid_q <= if_resp_valid_d;
            if_resp_data_q  <= if_resp_data_d;
            ls_resp_valid_q <= ls_resp_valid_d;
            ls_resp_data_q  <= ls_resp_data_d;
        end
    end

    assign if_req_ready_o  = grant_if;
    assign ls_req_ready_o  = grant_ls;
    assign mem_req_valid_o = (state_q == StIssue);
    assign mem_write_o     = mem_write_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign mem_wmask_o     = mem_wmask_q;
    assign if_resp_valid_o = if_resp_valid_q;
    assign if_resp_data_o  = if_resp_data_q;
    assign ls_resp_valid_o = ls_resp_valid_q;
    assign ls_resp_data_o  = ls_resp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven transactions with a response
// scoreboard, plus stall, stray-response, starvation and mid-transaction reset sequences.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 64;
    localparam int unsigned SM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req_valid = 1'b0;
    logic          if_req_ready;
    logic [AW-1:0] if_addr = '0;
    logic          if_resp_valid;
    logic [DW-1:0] if_resp_data;
    logic          ls_req_valid = 1'b0;
    logic          ls_req_ready;
    logic          ls_write = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic [3:0]    ls_wmask = '0;
    logic          ls_resp_valid;
    logic [DW-1:0] ls_resp_data;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_resp_data = '0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .STARVE_MAX (SM)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_req_valid_i   (if_req_valid),
        .if_req_ready_o   (if_req_ready),
        .if_addr_i        (if_addr),
        .if_resp_valid_o  (if_resp_valid),
        .if_resp_data_o   (if_resp_data),
        .ls_req_valid_i   (ls_req_valid),
        .ls_req_ready_o   (ls_req_ready),
        .ls_write_i       (ls_write),
        .ls_addr_i        (ls_addr),
        .ls_wdata_i       (ls_wdata),
        .ls_wmask_i       (ls_wmask),
        .ls_resp_valid_o  (ls_resp_valid),
        .ls_resp_data_o   (ls_resp_data),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_write_o      (mem_write),
        .mem_addr_o       (mem_addr),
        .mem_wdata_o      (mem_wdata),
        .mem_wmask_o      (mem_wmask),
        .mem_resp_valid_i (mem_resp_valid),
        .mem_resp_data_i  (mem_resp_data)
    );

    typedef struct {
        logic          if_v;
        logic [AW-1:0] if_a;
        logic          ls_v;
        logic          ls_w;
        logic [AW-1:0] ls_a;
        logic [DW-1:0] ls_d;
        logic [3:0]    ls_m;
        logic [DW-1:0] rdata;
        logic          exp_ls;
    } vec_t;

    typedef struct {
        logic          is_ls;
        logic [DW-1:0] data;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t vecs[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // One complete transaction; stall = extra ISSUE cycles with mem_req_ready low.
    task automatic do_txn(input vec_t v, input int stall);
        exp_t          e;
        logic          e_write;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [3:0]    e_mask;
        @(negedge clk);
        if_req_valid  = v.if_v;
        if_addr       = v.if_a;
        ls_req_valid  = v.ls_v;
        ls_write      = v.ls_w;
        ls_addr       = v.ls_a;
        ls_wdata      = v.ls_d;
        ls_wmask      = v.ls_m;
        mem_req_ready = 1'b0;
        #1;
        check("ls_req_ready_idle", ls_req_ready, v.exp_ls);
        check("if_req_ready_idle", if_req_ready, !v.exp_ls);
        e_write = v.exp_ls & v.ls_w;
        e_addr  = v.exp_ls ? v.ls_a : v.if_a;
        e_wdata = v.exp_ls ? v.ls_d : '0;
        e_mask  = v.exp_ls ? v.ls_m : MASK_D;
        e.is_ls = v.exp_ls;
        e.data  = e_write ? '0 : v.rdata;
        sb.push_back(e);
        for (int c = 0; c <= stall; c++) begin
            @(negedge clk);
            // Both clients keep requesting with changed fields: nothing may leak through.
            if_req_valid = 1'b1;
            ls_req_valid = 1'b1;
            if_addr      = ~v.if_a;
            ls_write     = ~v.ls_w;
            ls_addr      = ~v.ls_a;
            ls_wdata     = ~v.ls_d;
            ls_wmask     = ~v.ls_m;
            #1;
            check("issue_mem_req_valid", mem_req_valid, 1'b1);
            check("issue_mem_write", mem_write, e_write);
            check("issue_mem_addr", mem_addr, e_addr);
            check("issue_mem_wdata", mem_wdata, e_wdata);
            check("issue_mem_wmask", mem_wmask, e_mask);
            check("issue_readies", {if_req_ready, ls_req_ready}, 2'b00);
            check("issue_no_resp", {if_resp_valid, ls_resp_valid}, 2'b00);
            if (c == stall) mem_req_ready = 1'b1;
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        check("wait_mem_req_valid", mem_req_valid, 1'b0);
        check("wait_readies", {if_req_ready, ls_req_ready}, 2'b00);
        if_req_valid   = 1'b0;
        ls_req_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = v.rdata;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            check("resp_if_valid", if_resp_valid, !e.is_ls);
            check("resp_ls_valid", ls_resp_valid, e.is_ls);
            check("resp_data", e.is_ls ? ls_resp_data : if_resp_data, e.data);
        end
        @(negedge clk);
        check("resp_pulse_end", {if_resp_valid, ls_resp_valid}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic exp_ls;
        vecs[0] = '{if_v: 1'b1, if_a: 64'h8000_0000, ls_v: 1'b0, ls_w: 1'b0, ls_a: 64'h0,
                    ls_d: 64'h0, ls_m: 4'b0000, rdata: 64'h1122_3344_5566_7788, exp_ls: 1'b0};
        vecs[1] = '{if_v: 1'b1, if_a: 64'h8000_0040, ls_v: 1'b1, ls_w: 1'b1,
                    ls_a: 64'h8000_1000, ls_d: 64'hdead_beef_cafe_f00d, ls_m: MASK_W,
                    rdata: 64'h5555_aaaa_5555_aaaa, exp_ls: 1'b1};
        vecs[2] = '{if_v: 1'b0, if_a: 64'h0, ls_v: 1'b1, ls_w: 1'b0, ls_a: 64'h3,
                    ls_d: 64'h0bad_0bad_0bad_0bad, ls_m: MASK_B, rdata: 64'ha5,
                    exp_ls: 1'b1};
        vecs[3] = '{if_v: 1'b1, if_a: 64'h8000_0044, ls_v: 1'b1, ls_w: 1'b0,
                    ls_a: 64'hffff_ffff_ffff_fffe, ls_d: 64'h0, ls_m: MASK_H,
                    rdata: 64'h0000_0000_0000_beef, exp_ls: 1'b1};
        vecs[4] = '{if_v: 1'b1, if_a: 64'h1234_5678_9abc_def0, ls_v: 1'b0, ls_w: 1'b1,
                    ls_a: 64'h77, ls_d: 64'h77, ls_m: MASK_D,
                    rdata: 64'hffff_ffff_ffff_ffff, exp_ls: 1'b0};
        vecs[5] = '{if_v: 1'b0, if_a: 64'h0, ls_v: 1'b1, ls_w: 1'b1, ls_a: 64'h8000_2008,
                    ls_d: 64'h0123_4567_89ab_cdef, ls_m: MASK_D,
                    rdata: 64'h9999_9999_9999_9999, exp_ls: 1'b1};

        // Asynchronous reset state, before any clock edge.
        #1;
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_mem_wmask", mem_wmask, 4'b0000);
        check("rst_resp_valid", {if_resp_valid, ls_resp_valid}, 2'b00);
        check("rst_resp_data", if_resp_data | ls_resp_data, '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) do_txn(vecs[i], 0);

        // Memory holds off the request for five cycles.
        v = vecs[0];
        v.if_a  = 64'h8000_0100;
        v.rdata = 64'hcafe_0000_0000_0001;
        do_txn(v, 5);

        // Completions arriving while idle must be ignored.
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hbad0_bad0_bad0_bad0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stray_resp_valid", {if_resp_valid, ls_resp_valid}, 2'b00);
            check("stray_mem_req_valid", mem_req_valid, 1'b0);
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;

        // Reset while a store waits for its completion.
        @(negedge clk);
        ls_req_valid = 1'b1;
        ls_write     = 1'b1;
        ls_addr      = 64'h8000_3000;
        ls_wdata     = 64'h1111_2222_3333_4444;
        ls_wmask     = MASK_W;
        @(negedge clk);
        ls_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("pre_rst_mem_write", mem_write, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_req_valid", mem_req_valid, 1'b0);
        check("midrst_mem_write", mem_write, 1'b0);
        check("midrst_mem_addr", mem_addr, '0);
        check("midrst_mem_wdata", mem_wdata, '0);
        check("midrst_mem_wmask", mem_wmask, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h4444_3333_2222_1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            check("postrst_resp_valid", {if_resp_valid, ls_resp_valid}, 2'b00);
            check("postrst_mem_req_valid", mem_req_valid, 1'b0);
        end

        // Both clients contend on every arbitration.
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_ls = (k != SM);
`else
            exp_ls = 1'b1;
`endif
            v = '{if_v: 1'b1, if_a: 64'h8000_0000 + 64'(k * 4), ls_v: 1'b1, ls_w: 1'b0,
                  ls_a: 64'h9000_0000 + 64'(k * 8), ls_d: 64'h0, ls_m: MASK_D,
                  rdata: 64'h0f0f_0000_0000_0000 + 64'(k), exp_ls: exp_ls};
            do_txn(v, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, 64, data width of all data buses.
REQ-002 Parameter ADDR_W, 64, address width of all address buses.
REQ-003 Parameter STARVE_MAX, 4, consecutive lost arbitrations before fetch is forced to win.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 IfReqValid / IfReqReady  in / out  1 / 1  fetch read-request handshake.
REQ-007 IfAddr  in  ADDR_W  fetch address.
REQ-008 IfRespValid / IfRespData  out / out  1 / DATA_W  fetch response pulse and data.
REQ-009 LsReqValid / LsReqReady  in / out  1 / 1  load-store request handshake.
REQ-010 LsWrite, LsAddr, LsWdata, LsWmask  in  1, ADDR_W, DATA_W, 4  store flag, address, store data, size mask (0001 byte, 0010 half, 0100 word, 1000 double).
REQ-011 LsRespValid / LsRespData  out / out  1 / DATA_W  load-store response pulse and raw load data.
REQ-012 MemReqValid / MemReqReady  out / in  1 / 1  shared memory port request handshake.
REQ-013 MemWrite, MemAddr, MemWdata, MemWmask  out  1, ADDR_W, DATA_W, 4  registered request fields.
REQ-014 MemRespValid / MemRespData  in / in  1 / DATA_W  memory completion and read data.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT; exactly one transaction outstanding.
REQ-016 In IDLE, the winner's ReqReady SHALL be driven high combinationally; the loser's ReqReady and all ReqReady outside IDLE SHALL be low.
REQ-017 Default arbitration: LsReqValid wins over IfReqValid when both are high in the same cycle.
REQ-018 On handshake, owner, write flag, address, wdata, mask SHALL be latched; fetch requests latch MemWrite=0, MemWmask=1000, MemWdata=0; FSM goes to ISSUE.
REQ-019 ISSUE: MemReqValid=1 with latched fields held stable; on MemReqReady=1 go to WAIT.
REQ-020 WAIT: on MemRespValid=1 go to IDLE and register response for the owner.
REQ-021 The owner's RespValid SHALL pulse exactly one cycle, the cycle after MemRespValid is sampled in WAIT; RespData = MemRespData for reads, 0 for writes; non-owner RespValid stays 0.
REQ-022 MemRespValid outside WAIT SHALL be ignored; MemReqValid SHALL be 0 outside ISSUE.
REQ-023 Minimum transaction: accept cycle N, MemReqValid cycle N+1, RespValid cycle N+3 with zero-wait memory; next accept may occur in cycle N+3 (IDLE).
REQ-024 Request fields SHALL be passed unmodified; no address arithmetic, extension or alignment in this block.

Reset
REQ-025 On rst_n low, asynchronously: state IDLE, all RespValid, MemReqValid, MemWrite 0, all data/address/mask registers 0, starvation counter 0.
REQ-026 Reset mid-transaction SHALL drop the pending request without a response.

Configuration
REQ-027 With MEM_ARB_STARVE_GUARD_EN defined: a counter SHALL increment when fetch loses an arbitration while IfReqValid=1, clear when fetch wins, and when counter equals STARVE_MAX fetch SHALL win the next contested arbitration.
REQ-028 Without MEM_ARB_STARVE_GUARD_EN: strict load-store priority, no counter logic.

Structure
REQ-029 FSM state encoding, owner encoding and mask constants (MASK_B/H/W/D) SHALL live in the shared package.
REQ-030 One sub-module, mem_arb_starve_ctr, SHALL hold the starvation counter, instantiated only under MEM_ARB_STARVE_GUARD_EN.

Verification
REQ-031 IfReqValid=1, IfAddr=0x80000000, MemReqReady=1, MemRespValid next cycle with 0x1122334455667788 -> IfRespValid one cycle, IfRespData=0x1122334455667788.
REQ-032 Both valid same cycle, LsWrite=1, LsAddr=0x80001000, LsWmask=0100 -> LsReqReady=1, IfReqReady=0, MemWrite=1, MemWmask=0100, LsRespData=0.
REQ-033 MemReqReady held low 5 cycles in ISSUE -> MemReqValid and fields stable 5 cycles, no response.
REQ-034 Guard enabled, STARVE_MAX=4, both valid continuously -> fetch granted on 5th arbitration, counter cleared.
REQ-035 rst_n low during WAIT, then MemRespValid=1 after release -> no RespValid pulse, state IDLE, outputs 0.
